// File: rtl/down_counter_timer_pkg.sv
// Shared constants for the down-counter timer: FSM state encoding and default width.
// Optional feature macro used by this slice: DOWN_COUNTER_AUTO_RELOAD_EN.
package down_counter_timer_pkg;

  localparam int DEFAULT_NUM_BITS = 4;
  localparam int STATE_W          = 2;

  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_PAUSE = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/down_counter_timer_if.sv
// Load handshake, count control and status bundle for down_counter_timer.
// auto_reload exists only when DOWN_COUNTER_AUTO_RELOAD_EN is defined.
interface down_counter_timer_if
  import down_counter_timer_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) ();

  // A load transfers on a rising clk edge where load_valid && load_ready; the
  // master may drop or change load_value at will while load_ready is low.
  logic                load_valid;
  logic [NUM_BITS-1:0] load_value;
  logic                load_ready;
  logic                enable;
  logic [NUM_BITS-1:0] value;
  logic                busy;
  logic                done;
  state_t              state;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic                auto_reload;
`endif

  modport master (
    output load_valid, load_value, enable,
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    output auto_reload,
`endif
    input  load_ready, value, busy, done, state
  );

  modport slave (
    input  load_valid, load_value, enable,
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    input  auto_reload,
`endif
    output load_ready, value, busy, done, state
  );

endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter with pause and one-cycle terminal-count pulse.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to add auto_reload and a stored reload value.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int NUM_BITS = DEFAULT_NUM_BITS
) (
  input  logic            clk,
  input  logic            reset,
  down_counter_timer_if.slave bus
);

  state_t              state_q;
  logic [NUM_BITS-1:0] value_q;
  logic                done_q;
  logic                load_ready;
  logic                load_fire;
  logic                reload_now;

  assign load_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign load_fire  = bus.load_valid && load_ready;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [NUM_BITS-1:0] reload_q;

  // A stored zero never reloads, so a zero load always terminates in DONE.
  assign reload_now = bus.auto_reload && (reload_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reload_q <= '0;
    end else if (load_fire) begin
      reload_q <= bus.load_value;
    end
  end
`else
  assign reload_now = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (load_fire) begin
            value_q <= bus.load_value;
            if (bus.load_value != '0) begin
              state_q <= ST_RUN;
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (bus.enable) begin
            // Terminal step also covers value 0 so the count can never wrap.
            if (value_q <= NUM_BITS'(1)) begin
              done_q <= 1'b1;
              if (reload_now) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                value_q <= reload_q;
`endif
                state_q <= ST_RUN;
              end else begin
                value_q <= '0;
                state_q <= ST_DONE;
              end
            end else begin
              value_q <= value_q - NUM_BITS'(1);
              state_q <= ST_RUN;
            end
          end else begin
            state_q <= ST_PAUSE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          value_q <= '0;
        end
      endcase
    end
  end

  assign bus.load_ready = load_ready;
  assign bus.value      = value_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign bus.state      = state_q;

endmodule

// File: doc/down_counter_timer.md
DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

Interface
REQ-001 Parameter NUM_BITS SHALL be provided: default 4; width of the counter and of the load value.
REQ-002 Port clk SHALL be provided: input, 1 bit; clock, all state updates on its rising edge.
REQ-003 Port reset SHALL be provided: input, 1 bit; reset, asynchronous, active-high.
REQ-004 Port load_valid SHALL be provided: input, 1 bit; requests loading of load_value.
REQ-005 Port load_value SHALL be provided: input, NUM_BITS bits; start count.
REQ-006 Port load_ready SHALL be provided: output, 1 bit; block accepts a load this cycle.
REQ-007 Port enable SHALL be provided: input, 1 bit; count permitted when high, pause when low.
REQ-008 Port value SHALL be provided: output, NUM_BITS bits; current count.
REQ-009 Port busy SHALL be provided: output, 1 bit; high in RUN or PAUSE.
REQ-010 Port done SHALL be provided: output, 1 bit; one-cycle terminal-count pulse.

Function
REQ-011 The FSM SHALL have states IDLE, RUN, PAUSE and DONE.
REQ-012 load_ready SHALL be high exactly in IDLE and DONE.
REQ-013 A load SHALL be accepted on a rising edge where load_valid && load_ready: value <= load_value.
REQ-014 On acceptance, a nonzero load_value SHALL move the FSM to RUN; a zero load_value SHALL move it to DONE.
REQ-015 load_valid while load_ready is low SHALL be ignored with no state change.
REQ-016 In RUN or PAUSE with enable high, value SHALL decrement by 1 per edge and the state SHALL become RUN.
REQ-017 In RUN with enable low, value SHALL hold and the state SHALL become PAUSE.
REQ-018 In PAUSE with enable low, value SHALL hold.
REQ-019 A decrement from 1 to 0 SHALL move the FSM to DONE.
REQ-020 value SHALL never wrap below 0.
REQ-021 done SHALL be registered and high for exactly the first cycle of each DONE entry, including entry by a zero load.
REQ-022 With enable held high, loading N>0 SHALL give value==0 and done==1 in the Nth cycle after the accepting edge.
REQ-023 In DONE, value SHALL hold 0 until a new load is accepted.
REQ-024 A load in the same cycle that done is high SHALL be accepted normally.
REQ-025 done SHALL be low at all times outside the first DONE-entry cycle.

Reset
REQ-026 Assertion of reset SHALL immediately force state IDLE, value 0, done 0 and busy 0, so that load_ready is 1.
REQ-027 Reset SHALL override any in-progress count or load in the same cycle.
REQ-028 No reset release SHALL produce a done pulse.

Configuration
REQ-029 Macro DOWN_COUNTER_AUTO_RELOAD_EN SHALL, when defined, add input port auto_reload (1 bit) and an internal register holding the last accepted load_value.
REQ-030 With DOWN_COUNTER_AUTO_RELOAD_EN defined and auto_reload high at the 1->0 decrement, value SHALL instead load the stored value, the FSM SHALL stay in RUN and done SHALL still pulse one cycle.
REQ-031 With DOWN_COUNTER_AUTO_RELOAD_EN defined, a stored value of 0 SHALL never trigger a reload (zero loads go to DONE).
REQ-032 With DOWN_COUNTER_AUTO_RELOAD_EN undefined, port auto_reload and the reload register SHALL be absent and behaviour SHALL match REQ-019.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration (IDLE, RUN, PAUSE, DONE) and the default NUM_BITS constant.
REQ-034 The design SHALL be a single module with no sub-modules; FSM and datapath are small enough to sit together.

Verification
REQ-035 The bench SHALL cover basic count: reset, load 5, enable high -> value 4,3,2,1,0 on successive cycles, done=1 only with value 0, load_ready=1 after.
REQ-036 The bench SHALL cover pause: load 6, enable high 2 cycles, low 3 cycles -> value holds 4, state PAUSE, busy=1; then enable high -> reaches 0 four cycles later.
REQ-037 The bench SHALL cover zero and maximum loads: load 0 -> done pulses next cycle, busy never high; load 15 (NUM_BITS=4) -> done after exactly 15 enabled cycles, no wrap.
REQ-038 The bench SHALL cover ignored and back-to-back loads: load_valid with value 9 during RUN -> no effect; load 3 in the cycle done is high -> accepted, value=3.
REQ-039 The bench SHALL cover async reset mid-count: load 10, reset pulse between edges at value 7 -> value=0 and IDLE immediately, no done.
REQ-040 With DOWN_COUNTER_AUTO_RELOAD_EN defined, the bench SHALL cover auto_reload=1 with load 3 -> sequence 3,2,1,3,2,1..., done pulses every 3 cycles, busy stays 1.
